load_store_unit: RTL and testbench

// - Multi-cycle memory stage directly downstream of the ALU stage.
// - Takes the ALU result as the address and the second register operand as store data.
// - Runs load/store requests on a req/gnt/rvalid memory bus and stalls the CPU until the access completes.
// - Returns load data to the write-back mux, lane-steered and sign/zero-extended.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/lsu_align.sv | 56 +++++
 rtl/load_store_unit.sv | 163 ++++++++++++++++
 tb/tb_load_store_unit.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU memory stage: access sizes, LSU states and bus widths.
package cpu_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    // Access size as carried on op_size; 2'b11 is reserved and handled as a word.
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StReq  = 2'b01,
        StWait = 2'b10,
        StResp = 2'b11
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Lane logic for the load/store unit: alignment check, byte enables, store lane
// replication and load lane extraction with sign/zero extension. Purely combinational.
module lsu_align
    import cpu_pkg::*;
(
    input  logic [1:0]        size,
    input  logic [1:0]        offset,
    input  logic              sign_ext,
    input  logic [DATA_W-1:0] store_data,
    input  logic [DATA_W-1:0] load_raw,
    output logic              aligned,
    output logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] store_lanes,
    output logic [DATA_W-1:0] load_ext
);

    logic [7:0]  load_byte;
    logic [15:0] load_half;

    // Pick the addressed byte and halfword lanes out of the returned word.
    always_comb begin
        unique case (offset)
            2'd0:    load_byte = load_raw[7:0];
            2'd1:    load_byte = load_raw[15:8];
            2'd2:    load_byte = load_raw[23:16];
            default: load_byte = load_raw[31:24];
        endcase
        load_half = offset[1] ? load_raw[31:16] : load_raw[15:0];
    end

    // Per-size alignment, enables, store replication and load extension.
    always_comb begin
        aligned     = 1'b1;
        be          = 4'b1111;
        store_lanes = store_data;
        load_ext    = load_raw;
        case (size)
            SIZE_BYTE: begin
                be          = 4'b0001 << offset;
                store_lanes = {4{store_data[7:0]}};
                load_ext    = {{24{sign_ext & load_byte[7]}}, load_byte};
            end
            SIZE_HALF: begin
                aligned     = ~offset[0];
                be          = 4'b0011 << offset;
                store_lanes = {2{store_data[15:0]}};
                load_ext    = {{16{sign_ext & load_half[15]}}, load_half};
            end
            default: begin
                // Word, and the reserved encoding treated as word.
                aligned = (offset == 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Multi-cycle memory stage: turns ALU-stage load/store ops into req/gnt/rvalid bus
// transactions, stalls the CPU while an access is in flight and returns extended load data.
module load_store_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 16,
    parameter logic [DATA_W-1:0] RESET_RDATA    = 32'h0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    input  logic              op_write,
    input  logic [1:0]        op_size,
    input  logic              op_signed,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              op_ready,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              misalign,
    output logic              bus_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    output logic [BE_W-1:0]   bus_be,
    input  logic              bus_gnt,
    input  logic              bus_rvalid,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int unsigned CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_e       state_q;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic             we_q;
    logic [1:0]       size_q;
    logic [1:0]       offset_q;
    logic             signed_q;

    logic [1:0]        al_size;
    logic [1:0]        al_offset;
    logic              al_signed;
    logic              al_aligned;
    logic [BE_W-1:0]   al_be;
    logic [DATA_W-1:0] al_wdata;
    logic [DATA_W-1:0] al_load;

    logic idle;
    logic busy;

    assign idle = (state_q == StIdle);
    assign busy = (state_q == StReq) | (state_q == StWait);

    // One lane unit serves both paths: live op fields in IDLE, latched ones while busy.
    always_comb begin
        al_size   = idle ? op_size   : size_q;
        al_offset = idle ? addr[1:0] : offset_q;
        al_signed = idle ? op_signed : signed_q;
    end

    lsu_align u_align (
        .size        (al_size),
        .offset      (al_offset),
        .sign_ext    (al_signed),
        .store_data  (wdata),
        .load_raw    (bus_rdata),
        .aligned     (al_aligned),
        .be          (al_be),
        .store_lanes (al_wdata),
        .load_ext    (al_load)
    );

    // Handshake to the pipeline; stall drops in RESP so the CPU advances with rdata_valid.
    always_comb begin
        op_ready = idle;
        stall    = (op_valid & op_ready & al_aligned) | busy;
    end

    // Access FSM with the latched request, timeout counter and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            tmo_cnt_q   <= '0;
            we_q        <= 1'b0;
            size_q      <= SIZE_BYTE;
            offset_q    <= 2'b00;
            signed_q    <= 1'b0;
            rdata       <= RESET_RDATA;
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            bus_req     <= 1'b0;
            bus_we      <= 1'b0;
            bus_addr    <= '0;
            bus_wdata   <= '0;
            bus_be      <= '0;
        end else begin
            rdata_valid <= 1'b0;
            misalign    <= 1'b0;
            bus_err     <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    tmo_cnt_q <= '0;
                    if (op_valid) begin
                        if (al_aligned) begin
                            state_q   <= StReq;
                            we_q      <= op_write;
                            size_q    <= op_size;
                            offset_q  <= addr[1:0];
                            signed_q  <= op_signed;
                            bus_req   <= 1'b1;
                            bus_we    <= op_write;
                            bus_addr  <= {addr[ADDR_W-1:2], 2'b00};
                            bus_be    <= al_be;
                            bus_wdata <= al_wdata;
                        end else begin
                            misalign <= 1'b1;
                        end
                    end
                end
                StReq: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (bus_gnt && bus_rvalid) begin
                        state_q     <= StResp;
                        bus_req     <= 1'b0;
                        rdata_valid <= 1'b1;
                        if (!we_q) rdata <= al_load;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        // A grant without data on the last allowed cycle still aborts,
                        // so the access never exceeds the timeout budget.
                        state_q <= StIdle;
                        bus_req <= 1'b0;
                        bus_err <= 1'b1;
                        rdata   <= RESET_RDATA;
                    end else if (bus_gnt) begin
                        state_q <= StWait;
                        bus_req <= 1'b0;
                    end
                end
                StWait: begin
                    tmo_cnt_q <= tmo_cnt_q + 1'b1;
                    if (bus_rvalid) begin
                        state_q     <= StResp;
                        rdata_valid <= 1'b1;
                        if (!we_q) rdata <= al_load;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        state_q <= StIdle;
                        bus_err <= 1'b1;
                        rdata   <= RESET_RDATA;
                    end
                end
                default: begin
                    // RESP: completion already flagged; late bus activity is ignored.
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: a vector table at minimum latency plus
// hand-written latency, timeout and reset-in-flight sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_signed;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        op_ready;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        misalign;
    logic        bus_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_be;
    logic        bus_gnt;
    logic        bus_rvalid;
    logic [31:0] bus_rdata;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (16),
        .RESET_RDATA    (32'h0)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .op_valid    (op_valid),
        .op_write    (op_write),
        .op_size     (op_size),
        .op_signed   (op_signed),
        .addr        (addr),
        .wdata       (wdata),
        .op_ready    (op_ready),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .misalign    (misalign),
        .bus_err     (bus_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_wdata   (bus_wdata),
        .bus_be      (bus_be),
        .bus_gnt     (bus_gnt),
        .bus_rvalid  (bus_rvalid),
        .bus_rdata   (bus_rdata)
    );

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mem;
        logic        exp_mis;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_rdata;
    } vec_t;

    localparam int NVEC = 13;
    vec_t vecs [NVEC];

    int checks = 0;
    int errors = 0;
    logic [31:0] model_rdata;

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0b, expected %0b", name, act, exp);
        end
    endtask

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        op_valid   = 1'b0;
        bus_gnt    = 1'b0;
        bus_rvalid = 1'b0;
    endtask

    task automatic present(input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] d);
        op_valid  = 1'b1;
        op_write  = w;
        op_size   = sz;
        op_signed = sg;
        addr      = a;
        wdata     = d;
    endtask

    initial begin
        //              wr  size   sgn  addr          wdata         mem           mis  be       bus_wdata     rdata
        vecs[0]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 1'b0, 4'b1111, 32'h0,        32'hDEAD_BEEF};
        vecs[1]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0,        32'hFFFF_FF80};
        vecs[2]  = '{1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'h0,        32'h80FF_FFFF, 1'b0, 4'b1000, 32'h0,        32'h0000_0080};
        vecs[3]  = '{1'b1, 2'b01, 1'b0, 32'h0000_0202, 32'h1234_ABCD, 32'h0,        1'b0, 4'b1100, 32'hABCD_ABCD, 32'h0};
        vecs[4]  = '{1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0,        32'h8001_7FFF, 1'b0, 4'b1100, 32'h0,        32'hFFFF_8001};
        vecs[5]  = '{1'b0, 2'b01, 1'b0, 32'h0000_0000, 32'h0,        32'h8001_F00F, 1'b0, 4'b0011, 32'h0,        32'h0000_F00F};
        vecs[6]  = '{1'b0, 2'b00, 1'b1, 32'h0000_0101, 32'h0,        32'h1234_5678, 1'b0, 4'b0010, 32'h0,        32'h0000_0056};
        vecs[7]  = '{1'b1, 2'b00, 1'b0, 32'h0000_0102, 32'h0000_00A5, 32'h0,        1'b0, 4'b0100, 32'hA5A5_A5A5, 32'h0};
        vecs[8]  = '{1'b1, 2'b10, 1'b0, 32'h0000_0300, 32'hCAFE_F00D, 32'h0,        1'b0, 4'b1111, 32'hCAFE_F00D, 32'h0};
        vecs[9]  = '{1'b0, 2'b10, 1'b0, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[10] = '{1'b0, 2'b01, 1'b0, 32'h0000_0203, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};
        vecs[11] = '{1'b0, 2'b11, 1'b0, 32'h0000_0010, 32'h0,        32'h0102_0304, 1'b0, 4'b1111, 32'h0,        32'h0102_0304};
        vecs[12] = '{1'b0, 2'b11, 1'b0, 32'h0000_0012, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,        32'h0};

        rst       = 1'b0;
        op_write  = 1'b0;
        op_size   = 2'b00;
        op_signed = 1'b0;
        addr      = 32'h0;
        wdata     = 32'h0;
        bus_rdata = 32'h0;
        quiet();
        model_rdata = 32'h0;

        // Reset state.
        #12;
        check1("reset_bus_req", bus_req, 1'b0);
        check1("reset_rdata_valid", rdata_valid, 1'b0);
        check32("reset_rdata", rdata, 32'h0);
        check32("reset_bus_be", {28'h0, bus_be}, 32'h0);
        check1("reset_op_ready", op_ready, 1'b1);
        check1("reset_stall", stall, 1'b0);
        tick();
        rst = 1'b1;
        tick();

        // Vector table, grant and response on the first request cycle.
        for (int i = 0; i < NVEC; i++) begin
            present(vecs[i].write, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata);
            bus_gnt    = 1'b0;
            bus_rvalid = 1'b0;
            #1;
            check1($sformatf("v%0d_stall_accept", i), stall, ~vecs[i].exp_mis);
            tick();
            op_valid = 1'b0;
            if (vecs[i].exp_mis) begin
                #1;
                check1($sformatf("v%0d_misalign", i), misalign, 1'b1);
                check1($sformatf("v%0d_no_req", i), bus_req, 1'b0);
                check1($sformatf("v%0d_no_stall", i), stall, 1'b0);
                check32($sformatf("v%0d_rdata_kept", i), rdata, model_rdata);
            end else begin
                bus_gnt    = 1'b1;
                bus_rvalid = 1'b1;
                bus_rdata  = vecs[i].mem;
                #1;
                check1($sformatf("v%0d_req", i), bus_req, 1'b1);
                check1($sformatf("v%0d_we", i), bus_we, vecs[i].write);
                check32($sformatf("v%0d_addr", i), bus_addr, {vecs[i].addr[31:2], 2'b00});
                check32($sformatf("v%0d_be", i), {28'h0, bus_be}, {28'h0, vecs[i].exp_be});
                if (vecs[i].write)
                    check32($sformatf("v%0d_wdata", i), bus_wdata, vecs[i].exp_wdata);
                check1($sformatf("v%0d_stall_busy", i), stall, 1'b1);
                check1($sformatf("v%0d_no_misalign", i), misalign, 1'b0);
                tick();
                bus_gnt    = 1'b0;
                bus_rvalid = 1'b0;
                #1;
                if (!vecs[i].write) model_rdata = vecs[i].exp_rdata;
                check1($sformatf("v%0d_rdata_valid", i), rdata_valid, 1'b1);
                check32($sformatf("v%0d_rdata", i), rdata, model_rdata);
                check1($sformatf("v%0d_stall_resp", i), stall, 1'b0);
                check1($sformatf("v%0d_req_done", i), bus_req, 1'b0);
            end
            tick();
            check1($sformatf("v%0d_valid_pulse", i), rdata_valid, 1'b0);
            check1($sformatf("v%0d_mis_pulse", i), misalign, 1'b0);
            check1($sformatf("v%0d_idle", i), op_ready, 1'b1);
        end

        // Word load, gnt at T+1, rvalid at T+3, next op held off while busy.
        present(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'h0);
        #1;
        check1("lat_stall_t0", stall, 1'b1);
        tick();
        present(1'b0, 2'b10, 1'b0, 32'h0000_0200, 32'h0);
        bus_gnt = 1'b1;
        #1;
        check1("lat_req_t1", bus_req, 1'b1);
        check1("lat_op_ready_t1", op_ready, 1'b0);
        check1("lat_stall_t1", stall, 1'b1);
        tick();
        quiet();
        #1;
        check1("lat_req_drop_t2", bus_req, 1'b0);
        check1("lat_stall_t2", stall, 1'b1);
        tick();
        bus_rvalid = 1'b1;
        bus_rdata  = 32'hDEAD_BEEF;
        #1;
        check1("lat_stall_t3", stall, 1'b1);
        check1("lat_no_valid_t3", rdata_valid, 1'b0);
        tick();
        quiet();
        #1;
        model_rdata = 32'hDEAD_BEEF;
        check1("lat_valid_t4", rdata_valid, 1'b1);
        check32("lat_rdata_t4", rdata, model_rdata);
        check1("lat_stall_t4", stall, 1'b0);
        tick();
        check1("lat_valid_t5", rdata_valid, 1'b0);
        check1("lat_no_second_req", bus_req, 1'b0);

        // Timeout: no grant ever.
        present(1'b0, 2'b10, 1'b0, 32'h0000_0040, 32'h0);
        tick();
        quiet();
        for (int c = 1; c <= 16; c++) begin
            #1;
            check1($sformatf("tmo_req_c%0d", c), bus_req, 1'b1);
            check1($sformatf("tmo_no_err_c%0d", c), bus_err, 1'b0);
            tick();
        end
        #1;
        model_rdata = 32'h0;
        check1("tmo_bus_err", bus_err, 1'b1);
        check1("tmo_req_low", bus_req, 1'b0);
        check1("tmo_idle", op_ready, 1'b1);
        check1("tmo_no_valid", rdata_valid, 1'b0);
        check32("tmo_rdata", rdata, model_rdata);
        tick();
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h1111_2222;
        #1;
        check1("tmo_err_pulse", bus_err, 1'b0);
        tick();
        quiet();
        #1;
        check1("stray_no_valid", rdata_valid, 1'b0);
        check1("stray_no_req", bus_req, 1'b0);
        check32("stray_rdata", rdata, model_rdata);
        tick();

        // Load to leave non-reset rdata, then reset during WAIT of the next load.
        present(1'b0, 2'b10, 1'b0, 32'h0000_0080, 32'h0);
        tick();
        op_valid   = 1'b0;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h5555_AAAA;
        tick();
        quiet();
        #1;
        check32("pre_rst_rdata", rdata, 32'h5555_AAAA);
        tick();
        present(1'b0, 2'b10, 1'b0, 32'h0000_0084, 32'h0);
        tick();
        op_valid = 1'b0;
        bus_gnt  = 1'b1;
        tick();
        quiet();
        #1;
        check1("wait_busy", op_ready, 1'b0);
        check1("wait_stall", stall, 1'b1);
        rst = 1'b0;
        #1;
        check1("rst_idle", op_ready, 1'b1);
        check1("rst_stall", stall, 1'b0);
        check32("rst_rdata", rdata, 32'h0);
        check32("rst_bus_be", {28'h0, bus_be}, 32'h0);
        check32("rst_bus_addr", bus_addr, 32'h0);
        tick();
        rst        = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h7777_7777;
        tick();
        quiet();
        #1;
        check1("rst_stray_no_valid", rdata_valid, 1'b0);
        check32("rst_stray_rdata", rdata, 32'h0);
        tick();
        present(1'b0, 2'b10, 1'b0, 32'h0000_0088, 32'h0);
        tick();
        op_valid   = 1'b0;
        bus_gnt    = 1'b1;
        bus_rvalid = 1'b1;
        bus_rdata  = 32'h0BAD_F00D;
        #1;
        check32("post_rst_addr", bus_addr, 32'h0000_0088);
        tick();
        quiet();
        #1;
        check1("post_rst_valid", rdata_valid, 1'b1);
        check32("post_rst_rdata", rdata, 32'h0BAD_F00D);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
